// File: rtl/jbi_jpack_flow_ctl_if.sv
// Handshake bundle between the inbound queue trackers and the AOK/DOK flow-control block.
// The master side drives the enqueue/dequeue strobes and busy; the slave side returns requests and status.
interface jbi_jpack_flow_ctl_if #(
  parameter int unsigned CW = 5
);
  logic          hdr_enq;
  logic          hdr_deq;
  logic          dat_enq;
  logic          dat_deq;
  logic          jpack_busy;
  logic          send_aok_off;
  logic          send_dok_off;
  logic          send_aok_on;
  logic          send_dok_on;
  logic          aok_state;
  logic          dok_state;
  logic [CW-1:0] hdr_cnt;
  logic [CW-1:0] dat_cnt;
  logic          cnt_ovf_err;
  logic          cnt_unf_err;

  modport master (
    output hdr_enq, hdr_deq, dat_enq, dat_deq, jpack_busy,
    input  send_aok_off, send_dok_off, send_aok_on, send_dok_on,
    input  aok_state, dok_state, hdr_cnt, dat_cnt, cnt_ovf_err, cnt_unf_err
  );

  modport slave (
    input  hdr_enq, hdr_deq, dat_enq, dat_deq, jpack_busy,
    output send_aok_off, send_dok_off, send_aok_on, send_dok_on,
    output aok_state, dok_state, hdr_cnt, dat_cnt, cnt_ovf_err, cnt_unf_err
  );
endinterface

// File: rtl/jbi_jpack_flow_ctl.sv
// AOK/DOK flow-control request generator: tracks header/data queue occupancy and
// issues at most one hysteresis-driven on/off request per cycle to the J_PACK_OUT generator.
module jbi_jpack_flow_ctl #(
  parameter int unsigned CW         = 5,
  parameter int unsigned HDR_DEPTH  = 16,
  parameter int unsigned HDR_OFF_TH = 12,
  parameter int unsigned HDR_ON_TH  = 8,
  parameter int unsigned DAT_DEPTH  = 16,
  parameter int unsigned DAT_OFF_TH = 12,
  parameter int unsigned DAT_ON_TH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  jbi_jpack_flow_ctl_if.slave bus
);

  localparam int unsigned NREQ = 4;

  localparam logic [CW-1:0] HDR_FULL   = CW'(HDR_DEPTH);
  localparam logic [CW-1:0] HDR_OFF_C  = CW'(HDR_OFF_TH);
  localparam logic [CW-1:0] HDR_ON_C   = CW'(HDR_ON_TH);
  localparam logic [CW-1:0] DAT_FULL   = CW'(DAT_DEPTH);
  localparam logic [CW-1:0] DAT_OFF_C  = CW'(DAT_OFF_TH);
  localparam logic [CW-1:0] DAT_ON_C   = CW'(DAT_ON_TH);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Request selected for issue this cycle; list order is arbitration priority.
  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_AOK_OFF = 3'd1,
    REQ_DOK_OFF = 3'd2,
    REQ_AOK_ON  = 3'd3,
    REQ_DOK_ON  = 3'd4
  } req_e;

  // One-hot send register bit positions.
  localparam int unsigned S_AOK_OFF = 0;
  localparam int unsigned S_DOK_OFF = 1;
  localparam int unsigned S_AOK_ON  = 2;
  localparam int unsigned S_DOK_ON  = 3;

  logic [CW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [CW-1:0]   dat_cnt_q, dat_cnt_d;
  logic            aok_q, aok_d;
  logic            dok_q, dok_d;
  logic [NREQ-1:0] send_q, send_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            hdr_ovf, hdr_unf;
  logic            dat_ovf, dat_unf;
  logic            need_aok_off, need_aok_on;
  logic            need_dok_off, need_dok_on;
  req_e            sel;

  // Header occupancy: simultaneous enq+deq is a no-op even at the limits.
  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    hdr_ovf   = 1'b0;
    hdr_unf   = 1'b0;
    unique case ({bus.hdr_enq, bus.hdr_deq})
      2'b10: begin
        if (hdr_cnt_q == HDR_FULL) hdr_ovf   = 1'b1;
        else                       hdr_cnt_d = hdr_cnt_q + CNT_ONE;
      end
      2'b01: begin
        if (hdr_cnt_q == CNT_ZERO) hdr_unf   = 1'b1;
        else                       hdr_cnt_d = hdr_cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  // Data occupancy, same rules as the header channel.
  always_comb begin
    dat_cnt_d = dat_cnt_q;
    dat_ovf   = 1'b0;
    dat_unf   = 1'b0;
    unique case ({bus.dat_enq, bus.dat_deq})
      2'b10: begin
        if (dat_cnt_q == DAT_FULL) dat_ovf   = 1'b1;
        else                       dat_cnt_d = dat_cnt_q + CNT_ONE;
      end
      2'b01: begin
        if (dat_cnt_q == CNT_ZERO) dat_unf   = 1'b1;
        else                       dat_cnt_d = dat_cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  // Needs derive from registered state, so a request drops as soon as its state bit flips.
  always_comb begin
    need_aok_off = aok_q  && (hdr_cnt_q >= HDR_OFF_C);
    need_aok_on  = !aok_q && (hdr_cnt_q <= HDR_ON_C);
    need_dok_off = dok_q  && (dat_cnt_q >= DAT_OFF_C);
    need_dok_on  = !dok_q && (dat_cnt_q <= DAT_ON_C);
  end

  // Fixed-priority arbitration, suppressed entirely while downstream is busy.
  always_comb begin
    sel = REQ_NONE;
    if (!bus.jpack_busy) begin
      if      (need_aok_off) sel = REQ_AOK_OFF;
      else if (need_dok_off) sel = REQ_DOK_OFF;
      else if (need_aok_on)  sel = REQ_AOK_ON;
      else if (need_dok_on)  sel = REQ_DOK_ON;
    end
  end

  // Next-state for send pulses, AOK/DOK state bits and error pulses.
  always_comb begin
    send_d = '0;
    aok_d  = aok_q;
    dok_d  = dok_q;
    ovf_d  = hdr_ovf | dat_ovf;
    unf_d  = hdr_unf | dat_unf;
    unique case (sel)
      REQ_AOK_OFF: begin
        send_d[S_AOK_OFF] = 1'b1;
        aok_d             = 1'b0;
      end
      REQ_DOK_OFF: begin
        send_d[S_DOK_OFF] = 1'b1;
        dok_d             = 1'b0;
      end
      REQ_AOK_ON: begin
        send_d[S_AOK_ON] = 1'b1;
        aok_d            = 1'b1;
      end
      REQ_DOK_ON: begin
        send_d[S_DOK_ON] = 1'b1;
        dok_d            = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_q <= '0;
      dat_cnt_q <= '0;
      aok_q     <= 1'b1;
      dok_q     <= 1'b1;
      send_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      hdr_cnt_q <= hdr_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      aok_q     <= aok_d;
      dok_q     <= dok_d;
      send_q    <= send_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.send_aok_off = send_q[S_AOK_OFF];
  assign bus.send_dok_off = send_q[S_DOK_OFF];
  assign bus.send_aok_on  = send_q[S_AOK_ON];
  assign bus.send_dok_on  = send_q[S_DOK_ON];
  assign bus.aok_state    = aok_q;
  assign bus.dok_state    = dok_q;
  assign bus.hdr_cnt      = hdr_cnt_q;
  assign bus.dat_cnt      = dat_cnt_q;
  assign bus.cnt_ovf_err  = ovf_q;
  assign bus.cnt_unf_err  = unf_q;

endmodule

// File: tb/tb_jbi_jpack_flow_ctl.sv
// Directed bench for jbi_jpack_flow_ctl: an occupancy/state model checks every cycle,
// and literal expectations pin the key latencies and boundary cases.
module tb_jbi_jpack_flow_ctl;
  localparam int unsigned CW = 5;
  localparam int DEPTH = 16;
  localparam int OFF_TH = 12;
  localparam int ON_TH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  jbi_jpack_flow_ctl_if #(.CW(CW)) bus ();

  jbi_jpack_flow_ctl #(.CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as plain integers, requests chosen by priority rule.
  int m_h, m_d;
  bit m_aok, m_dok, m_ovf, m_unf;
  bit [3:0] m_send; // [0]aok_off [1]dok_off [2]aok_on [3]dok_on

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h <= 0; m_d <= 0; m_aok <= 1'b1; m_dok <= 1'b1;
      m_send <= '0; m_ovf <= 1'b0; m_unf <= 1'b0;
    end else begin
      m_send <= '0;
      if (!bus.jpack_busy) begin
        if (m_aok && m_h >= OFF_TH)       begin m_send <= 4'b0001; m_aok <= 1'b0; end
        else if (m_dok && m_d >= OFF_TH)  begin m_send <= 4'b0010; m_dok <= 1'b0; end
        else if (!m_aok && m_h <= ON_TH)  begin m_send <= 4'b0100; m_aok <= 1'b1; end
        else if (!m_dok && m_d <= ON_TH)  begin m_send <= 4'b1000; m_dok <= 1'b1; end
      end
      m_ovf <= (bus.hdr_enq && !bus.hdr_deq && m_h == DEPTH) ||
               (bus.dat_enq && !bus.dat_deq && m_d == DEPTH);
      m_unf <= (bus.hdr_deq && !bus.hdr_enq && m_h == 0) ||
               (bus.dat_deq && !bus.dat_enq && m_d == 0);
      if (bus.hdr_enq && !bus.hdr_deq && m_h < DEPTH) m_h <= m_h + 1;
      if (bus.hdr_deq && !bus.hdr_enq && m_h > 0)     m_h <= m_h - 1;
      if (bus.dat_enq && !bus.dat_deq && m_d < DEPTH) m_d <= m_d + 1;
      if (bus.dat_deq && !bus.dat_enq && m_d > 0)     m_d <= m_d - 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("hdr_cnt", int'(bus.hdr_cnt), m_h);
      chk("dat_cnt", int'(bus.dat_cnt), m_d);
      chk("aok_state", int'(bus.aok_state), int'(m_aok));
      chk("dok_state", int'(bus.dok_state), int'(m_dok));
      chk("send_aok_off", int'(bus.send_aok_off), int'(m_send[0]));
      chk("send_dok_off", int'(bus.send_dok_off), int'(m_send[1]));
      chk("send_aok_on", int'(bus.send_aok_on), int'(m_send[2]));
      chk("send_dok_on", int'(bus.send_dok_on), int'(m_send[3]));
      chk("ovf_err", int'(bus.cnt_ovf_err), int'(m_ovf));
      chk("unf_err", int'(bus.cnt_unf_err), int'(m_unf));
      chk("send_onehot", int'($countones({bus.send_aok_off, bus.send_dok_off,
                                           bus.send_aok_on, bus.send_dok_on}) <= 1), 1);
    end
  end

  // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic he, input logic hd, input logic de, input logic dd, input logic bz);
    bus.hdr_enq = he; bus.hdr_deq = hd;
    bus.dat_enq = de; bus.dat_deq = dd;
    bus.jpack_busy = bz;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sends_zero(input string nm);
    chk(nm, int'({bus.send_aok_off, bus.send_dok_off, bus.send_aok_on, bus.send_dok_on}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.hdr_enq = 1'b0; bus.hdr_deq = 1'b0;
    bus.dat_enq = 1'b0; bus.dat_deq = 1'b0;
    bus.jpack_busy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.hdr_enq = 1'b0; bus.hdr_deq = 1'b0;
    bus.dat_enq = 1'b0; bus.dat_deq = 1'b0;
    bus.jpack_busy = 1'b0;
    #12;
    chk("rst_hdr_cnt", int'(bus.hdr_cnt), 0);
    chk("rst_aok_state", int'(bus.aok_state), 1);
    chk("rst_dok_state", int'(bus.dok_state), 1);
    sends_zero("rst_sends");
    do_reset();
    chk_en = 1'b1;

    // AOK off after header occupancy reaches 12.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_hdr12", int'(bus.hdr_cnt), 12);
    sends_zero("t1_not_yet");
    idle(1);
    chk("t1_aok_off", int'(bus.send_aok_off), 1);
    chk("t1_aok_state", int'(bus.aok_state), 0);
    idle(1);
    sends_zero("t1_single");

    // Hysteresis: 9 gives nothing, 8 re-enables, back up to 11 gives nothing.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t2_no_on_at9", int'(bus.aok_state), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sends_zero("t2_at8_wait");
    idle(1);
    chk("t2_aok_on", int'(bus.send_aok_on), 1);
    chk("t2_aok_state", int'(bus.aok_state), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t2_hdr11", int'(bus.hdr_cnt), 11);
    chk("t2_still_on", int'(bus.aok_state), 1);

    // Both channels cross on the same edge: AOK first, DOK next cycle.
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t3_k_aok", int'(bus.send_aok_off), 1);
    chk("t3_k_dok", int'(bus.send_dok_off), 0);
    idle(1);
    chk("t3_k1_aok", int'(bus.send_aok_off), 0);
    chk("t3_k1_dok", int'(bus.send_dok_off), 1);
    idle(1);
    sends_zero("t3_done");

    // Busy holds DOK off until released.
    do_reset();
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      sends_zero("t4_busy");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_dok_off", int'(bus.send_dok_off), 1);
    chk("t4_dok_state", int'(bus.dok_state), 0);

    // Need vanishes under busy: no stale request.
    do_reset();
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      sends_zero("t4b_stale");
    end
    chk("t4b_dok_state", int'(bus.dok_state), 1);

    // Counter limits and error pulses.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_dat16", int'(bus.dat_cnt), 16);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_ovf", int'(bus.cnt_ovf_err), 1);
    chk("t5_hold16", int'(bus.dat_cnt), 16);
    idle(1);
    chk("t5_ovf_pulse", int'(bus.cnt_ovf_err), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_both_noerr", int'(bus.cnt_ovf_err), 0);
    chk("t5_both_16", int'(bus.dat_cnt), 16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_dat0", int'(bus.dat_cnt), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_unf", int'(bus.cnt_unf_err), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_hboth_noerr", int'(bus.cnt_unf_err), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_hdr_unf", int'(bus.cnt_unf_err), 1);
    idle(2);

    // Asynchronous reset with a pending AOK-off need.
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_hdr13", int'(bus.hdr_cnt), 13);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_hdr", int'(bus.hdr_cnt), 0);
    chk("t6_async_aok", int'(bus.aok_state), 1);
    sends_zero("t6_async_sends");
    bus.hdr_enq = 1'b0; bus.jpack_busy = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      sends_zero("t6_after_rel");
    end
    chk("t6_aok_state", int'(bus.aok_state), 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jbi_jpack_flow_ctl.md
Name: jbi_jpack_flow_ctl

Overview:
- Generates the AOK/DOK flow-control requests (send_aok_off/on, send_dok_off/on) consumed by the J_PACK_OUT generator.
- Tracks occupancy of the inbound request-header queue and the inbound write-data queue, and applies hysteresis thresholds to decide when to throttle and release JBus masters.
- Issues at most one request per cycle and never issues a duplicate on/off.
- Holds pending requests while the downstream J_PACK generator is busy with a DOK-fatal sequence.

Parameters:
- CW, 5, width of each occupancy counter.
- HDR_DEPTH, 16, header queue capacity in entries.
- HDR_OFF_TH, 12, header occupancy at or above which AOK is turned off.
- HDR_ON_TH, 8, header occupancy at or below which AOK is turned back on.
- DAT_DEPTH, 16, data queue capacity in entries.
- DAT_OFF_TH, 12, data occupancy at or above which DOK is turned off.
- DAT_ON_TH, 8, data occupancy at or below which DOK is turned back on.
- Legal settings require ON_TH < OFF_TH <= DEPTH < 2^CW. Other settings are illegal.

Ports:
- clk  in  1  JBus clock.
- rst  in  1  asynchronous reset, active-high.
- hdr_enq  in  1  one header entry written to the queue this cycle.
- hdr_deq  in  1  one header entry freed this cycle.
- dat_enq  in  1  one data entry written this cycle.
- dat_deq  in  1  one data entry freed this cycle.
- jpack_busy  in  1  downstream is in a DOK-fatal sequence and cannot accept requests.
- send_aok_off  out  1  registered one-cycle request pulse.
- send_dok_off  out  1  registered one-cycle request pulse.
- send_aok_on  out  1  registered one-cycle request pulse.
- send_dok_on  out  1  registered one-cycle request pulse.
- aok_state  out  1  1 = AOK currently on, as last signalled.
- dok_state  out  1  1 = DOK currently on, as last signalled.
- hdr_cnt  out  CW  header occupancy.
- dat_cnt  out  CW  data occupancy.
- cnt_ovf_err  out  1  registered pulse: enqueue attempted at full.
- cnt_unf_err  out  1  registered pulse: dequeue attempted at empty.

Behaviour:
- Reset (asynchronous, rst=1) sets the following values:
  - hdr_cnt = 0 and dat_cnt = 0.
  - aok_state = 1 and dok_state = 1.
  - All send_* = 0.
  - Both error outputs = 0.
  - Asserting reset mid-operation discards all pending requests. No pulse is emitted on the cycle reset deasserts.
- Counters update on each clk edge. Each channel is independent, with the same rules per channel:
  - enq only: count+1. If count == DEPTH, count holds and ovf_err pulses for one cycle.
  - deq only: count-1. If count == 0, count holds and unf_err pulses for one cycle.
  - enq and deq together: count unchanged and no error, including when count is 0 or DEPTH.
  - Each error output is the OR of its two channels.
- Need terms are combinational from the registered counts and states:
  - need_aok_off = aok_state && hdr_cnt >= HDR_OFF_TH.
  - need_aok_on = !aok_state && hdr_cnt <= HDR_ON_TH.
  - need_dok_off and need_dok_on are the same, using dat_cnt and the DAT_* thresholds.
  - Occupancy between the two thresholds creates no need (hysteresis band).
- Issue stage:
  - If jpack_busy = 0, the highest-priority need is selected in the order aok_off > dok_off > aok_on > dok_on.
  - On the next edge the selected send_* is registered high for one cycle, and the matching state bit flips on the same edge.
  - Non-selected needs stay pending and are re-evaluated in the next cycle.
  - If jpack_busy = 1, nothing is selected and all send_* are 0 next cycle. Needs persist until busy drops.
- Latency: a count reaching a threshold on edge N produces the send pulse in the cycle following edge N+1, provided the request wins arbitration and busy = 0.
- Invariants:
  - At most one send_* is high in any cycle.
  - An off request is never sent while its state is off; an on request is never sent while its state is on.
  - send_* outputs are never X after reset.
- Occupancy can cross back before a request issues. Example: the count drops below OFF_TH while blocked by busy. The need then vanishes and no request is sent (no stale request).

Test Plan:
- Reset, then 12 hdr_enq pulses with busy=0 -> hdr_cnt=12; single send_aok_off pulse 2 cycles after the 12th enqueue edge; aok_state=0; no other send_*.
- From hdr_cnt=12, aok_state=0: dequeue to 9 -> no request. Dequeue to 8 -> single send_aok_on, aok_state=1. Enqueue back to 11 -> no request (hysteresis).
- hdr_cnt and dat_cnt both cross 12 on the same edge -> send_aok_off in cycle k, send_dok_off in cycle k+1; never both high together.
- jpack_busy=1 held 5 cycles while dat_cnt reaches 12 -> no send_* during busy; send_dok_off in the cycle after the first edge with busy=0. Separately, dat_cnt drops to 11 during busy -> no send_* after busy drops.
- dat_cnt=16 with dat_enq only -> dat_cnt stays 16 and cnt_ovf_err is one cycle high. dat_cnt=0 with dat_deq only -> cnt_unf_err. dat_cnt=16 with dat_enq+dat_deq together -> no error and count remains 16.
- Assert rst asynchronously mid-stream with hdr_cnt=13 and a pending need -> outputs immediately return to reset values; no send_* pulse after release.
